// File: rtl/pipe_control_pkg.sv
// Shared state encodings and status-LED bit positions for pipe_control.
package pipe_control_pkg;

  // Camera configuration sequencer states
  typedef enum logic [1:0] {
    CFG_START  = 2'd0,
    CFG_WAIT   = 2'd1,
    CFG_ACTIVE = 2'd2,
    CFG_FAIL   = 2'd3
  } cfg_state_e;

  // Pipeline flush / filter-update states
  typedef enum logic [1:0] {
    FL_INITIAL = 2'd0,
    FL_IDLE    = 2'd1,
    FL_PENDING = 2'd2
  } fl_state_e;

  // Status LED bit positions; bits [3:0] carry the filter enables
  localparam int unsigned LED_FILTER_W = 32'd4;
  localparam int unsigned LED_FLUSH    = 32'd4;
  localparam int unsigned LED_ACTIVE   = 32'd5;
  localparam int unsigned LED_ERROR    = 32'd6;
  localparam int unsigned LED_SOF      = 32'd7;

endpackage

// File: rtl/pipe_control_sw_debounce.sv
// Single-bit switch conditioner: 2-flop synchronizer followed by a
// consecutive-mismatch counter that accepts a new level after DB_CYCLES.
module sw_debounce #(
  parameter int DB_CYCLES = 16
) (
  input  logic i_sysclk,
  input  logic i_rstn,
  input  logic sw_raw,
  output logic sw_db
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] cnt_r;
  logic          db_r;

  // Bring the asynchronous switch into the clock domain
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sw_raw;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level on the last one
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      cnt_r <= '0;
      db_r  <= 1'b0;
    end else if (sync2_r != db_r) begin
      if (cnt_r == CW'(DB_CYCLES - 1)) begin
        cnt_r <= '0;
        db_r  <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign sw_db = db_r;

endmodule

// File: rtl/pipe_control.sv
// Frame pipeline controller: configures the camera with bounded retries,
// debounces filter switches and applies filter changes on frame boundaries
// while requesting a pipeline flush around each change.
module pipe_control
  import pipe_control_pkg::*;
#(
  parameter int NUM_SW      = 4,
  parameter int DB_CYCLES   = 16,
  parameter int CFG_TIMEOUT = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic              i_sysclk,
  input  logic              i_rstn,
  input  logic              i_sof,
  input  logic              i_cfg_done,
  input  logic [NUM_SW-1:0] i_sw,
  output logic              o_cfg_start,
  output logic              o_pipe_flush,
  output logic [NUM_SW-1:0] o_filter_en,
  output logic              o_cfg_error,
  output logic [7:0]        o_status_leds
);

  localparam int TW = $clog2(CFG_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [NUM_SW-1:0] db_s;
  logic [NUM_SW-1:0] db_prev_r;
  logic              change_r;

  cfg_state_e        cfg_state_r;
  cfg_state_e        cfg_next_s;
  logic [TW-1:0]     tmo_r;
  logic [TW-1:0]     tmo_next_s;
  logic [RW-1:0]     retry_r;
  logic [RW-1:0]     retry_next_s;
  logic              cfg_start_r;
  logic              cfg_error_r;
  logic              cfg_active_r;

  fl_state_e         fl_state_r;
  fl_state_e         fl_next_s;
  logic              fen_load_s;
  logic              flush_r;
  logic [NUM_SW-1:0] fen_r;
  logic              sof_tgl_r;

  logic [NUM_SW+3:0] fen_ext_s;
  logic [7:0]        leds_s;

  genvar g;
  generate
    for (g = 0; g < NUM_SW; g++) begin : g_db
      sw_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .i_sysclk(i_sysclk),
        .i_rstn  (i_rstn),
        .sw_raw  (i_sw[g]),
        .sw_db   (db_s[g])
      );
    end
  endgenerate

  // Flag, one cycle later, any change of the debounced switch vector
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      db_prev_r <= '0;
      change_r  <= 1'b0;
    end else begin
      db_prev_r <= db_s;
      change_r  <= |(db_s ^ db_prev_r);
    end
  end

  // Configuration sequencer: start pulse, wait with timeout, retry or fail
  always_comb begin
    cfg_next_s   = cfg_state_r;
    tmo_next_s   = tmo_r;
    retry_next_s = retry_r;
    case (cfg_state_r)
      CFG_START: begin
        tmo_next_s = '0;
        cfg_next_s = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (i_cfg_done) begin
          cfg_next_s = CFG_ACTIVE;
        end else if ((tmo_r + TW'(1)) == TW'(CFG_TIMEOUT)) begin
          if (retry_r == RW'(MAX_RETRY)) begin
            cfg_next_s = CFG_FAIL;
          end else begin
            retry_next_s = retry_r + RW'(1);
            cfg_next_s   = CFG_START;
          end
        end else begin
          tmo_next_s = tmo_r + TW'(1);
        end
      end
      CFG_ACTIVE: cfg_next_s = CFG_ACTIVE;
      CFG_FAIL:   cfg_next_s = CFG_FAIL;
      default:    cfg_next_s = CFG_START;
    endcase
  end

  // Configuration state and its registered outputs
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      cfg_state_r  <= CFG_START;
      tmo_r        <= '0;
      retry_r      <= '0;
      cfg_start_r  <= 1'b0;
      cfg_error_r  <= 1'b0;
      cfg_active_r <= 1'b0;
    end else begin
      cfg_state_r  <= cfg_next_s;
      tmo_r        <= tmo_next_s;
      retry_r      <= retry_next_s;
      cfg_start_r  <= (cfg_state_r == CFG_START);
      cfg_error_r  <= (cfg_next_s == CFG_FAIL);
      cfg_active_r <= (cfg_next_s == CFG_ACTIVE);
    end
  end

  // Flush sequencer: filter enables are only ever loaded on a start-of-frame
  always_comb begin
    fl_next_s  = fl_state_r;
    fen_load_s = 1'b0;
    case (fl_state_r)
      FL_INITIAL: begin
        if (i_sof && (cfg_state_r == CFG_ACTIVE)) begin
          fen_load_s = 1'b1;
          fl_next_s  = FL_IDLE;
        end else begin
          fl_next_s  = FL_INITIAL;
        end
      end
      FL_IDLE: begin
        // A start-of-frame alongside a change is ignored; the change waits a frame
        if (change_r) begin
          fl_next_s = FL_PENDING;
        end else begin
          fl_next_s = FL_IDLE;
        end
      end
      FL_PENDING: begin
        if (i_sof) begin
          fen_load_s = 1'b1;
          // A fresh change on the frame boundary keeps the flush for one more frame
          if (change_r) begin
            fl_next_s = FL_PENDING;
          end else begin
            fl_next_s = FL_IDLE;
          end
        end else begin
          fl_next_s = FL_PENDING;
        end
      end
      default: fl_next_s = FL_INITIAL;
    endcase
  end

  // Flush state, flush request, filter enables and the frame heartbeat
  always_ff @(posedge i_sysclk) begin
    if (!i_rstn) begin
      fl_state_r <= FL_INITIAL;
      flush_r    <= 1'b1;
      fen_r      <= '0;
      sof_tgl_r  <= 1'b0;
    end else begin
      fl_state_r <= fl_next_s;
      flush_r    <= (fl_next_s != FL_IDLE);
      if (fen_load_s) begin
        fen_r <= db_s;
      end
      if (i_sof && (cfg_state_r == CFG_ACTIVE)) begin
        sof_tgl_r <= ~sof_tgl_r;
      end
    end
  end

  assign fen_ext_s = {4'b0000, fen_r};

  // Assemble the board status word from registered state only
  always_comb begin
    leds_s                 = 8'h00;
    leds_s[LED_FILTER_W-1:0] = fen_ext_s[3:0];
    leds_s[LED_FLUSH]      = flush_r;
    leds_s[LED_ACTIVE]     = cfg_active_r;
    leds_s[LED_ERROR]      = cfg_error_r;
    leds_s[LED_SOF]        = sof_tgl_r;
  end

  assign o_cfg_start   = cfg_start_r;
  assign o_pipe_flush  = flush_r;
  assign o_filter_en   = fen_r;
  assign o_cfg_error   = cfg_error_r;
  assign o_status_leds = leds_s;

endmodule

// File: tb/tb_pipe_control.sv
// Directed self-checking bench for pipe_control with short timing parameters.
module tb_pipe_control;

  localparam int NUM_SW      = 4;
  localparam int DB_CYCLES   = 4;
  localparam int CFG_TIMEOUT = 20;
  localparam int MAX_RETRY   = 2;

  logic              i_sysclk = 1'b0;
  logic              i_rstn;
  logic              i_sof;
  logic              i_cfg_done;
  logic [NUM_SW-1:0] i_sw;
  logic              o_cfg_start;
  logic              o_pipe_flush;
  logic [NUM_SW-1:0] o_filter_en;
  logic              o_cfg_error;
  logic [7:0]        o_status_leds;

  int   n_checks = 0;
  int   n_errors = 0;
  logic exp_tgl  = 1'b0;

  pipe_control #(
    .NUM_SW     (NUM_SW),
    .DB_CYCLES  (DB_CYCLES),
    .CFG_TIMEOUT(CFG_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .i_sysclk     (i_sysclk),
    .i_rstn       (i_rstn),
    .i_sof        (i_sof),
    .i_cfg_done   (i_cfg_done),
    .i_sw         (i_sw),
    .o_cfg_start  (o_cfg_start),
    .o_pipe_flush (o_pipe_flush),
    .o_filter_en  (o_filter_en),
    .o_cfg_error  (o_cfg_error),
    .o_status_leds(o_status_leds)
  );

  // 100 MHz system clock
  always #5 i_sysclk = ~i_sysclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; outputs are observed 1 ns after each edge
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge i_sysclk);
      #1;
    end
  endtask

  task automatic sof_cycle(input logic active);
    i_sof = 1'b1;
    tick(1);
    i_sof = 1'b0;
    if (active) exp_tgl = ~exp_tgl;
  endtask

  logic flush_seen;
  int   lat;
  int   pulses;
  int   p2;
  int   p3;
  int   err_at;

  initial begin
    i_rstn     = 1'b0;
    i_sof      = 1'b0;
    i_cfg_done = 1'b0;
    i_sw       = 4'b0000;
    tick(3);

    // Reset values
    check_val("rst_cfg_start", 32'(o_cfg_start), 32'd0);
    check_val("rst_flush", 32'(o_pipe_flush), 32'd1);
    check_val("rst_fen", 32'(o_filter_en), 32'd0);
    check_val("rst_err", 32'(o_cfg_error), 32'd0);
    check_val("rst_leds", 32'(o_status_leds), 32'h10);

    // Configuration completes, first frame clears the flush
    i_rstn = 1'b1;
    tick(1);
    check_val("start_pulse", 32'(o_cfg_start), 32'd1);
    tick(1);
    check_val("start_one_cycle", 32'(o_cfg_start), 32'd0);
    tick(3);
    i_cfg_done = 1'b1;
    tick(1);
    check_val("active_leds", 32'(o_status_leds), 32'h30);
    sof_cycle(1'b1);
    check_val("first_sof_flush", 32'(o_pipe_flush), 32'd0);
    check_val("first_sof_leds", 32'(o_status_leds), 32'hA0);

    // Bouncing switch never produces a change
    flush_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_sw = ((k % 2) == 0) ? 4'b0001 : 4'b0000;
      tick(1);
      flush_seen = flush_seen | o_pipe_flush;
    end
    i_sw = 4'b0000;
    tick(3);
    flush_seen = flush_seen | o_pipe_flush;
    check_val("bounce_no_change", 32'(flush_seen), 32'd0);

    // Stable switch: 2 sync + 4 debounce + 1 event + 1 flush register = 8 edges
    i_sw = 4'b0001;
    lat  = 0;
    for (int n = 1; n <= 12; n++) begin
      tick(1);
      if (o_pipe_flush && (lat == 0)) lat = n;
    end
    check_val("debounce_latency", 32'(lat), 32'd8);
    sof_cycle(1'b1);
    check_val("db_fen", 32'(o_filter_en), 32'h1);
    check_val("db_flush_clear", 32'(o_pipe_flush), 32'd0);

    // Back to 0000, then 0000 -> 0101 mid-frame
    i_sw = 4'b0000;
    tick(10);
    check_val("clr_pending", 32'(o_pipe_flush), 32'd1);
    sof_cycle(1'b1);
    check_val("clr_fen", 32'(o_filter_en), 32'h0);
    i_sw = 4'b0101;
    tick(7);
    check_val("chg_flush_early", 32'(o_pipe_flush), 32'd0);
    tick(1);
    check_val("chg_flush_set", 32'(o_pipe_flush), 32'd1);
    tick(3);
    check_val("chg_fen_hold", 32'(o_filter_en), 32'h0);
    sof_cycle(1'b1);
    check_val("chg_fen_load", 32'(o_filter_en), 32'h5);
    check_val("chg_flush_clear", 32'(o_pipe_flush), 32'd0);
    check_val("chg_leds", 32'(o_status_leds), 32'({exp_tgl, 3'b010, 4'b0101}));

    // Change event landing exactly on start-of-frame while pending
    i_sw = 4'b0111;
    tick(8);
    check_val("coinc_pending", 32'(o_pipe_flush), 32'd1);
    i_sw = 4'b1111;
    tick(7);
    sof_cycle(1'b1);
    check_val("coinc_fen", 32'(o_filter_en), 32'hF);
    check_val("coinc_flush_held", 32'(o_pipe_flush), 32'd1);
    tick(5);
    check_val("coinc_flush_frame", 32'(o_pipe_flush), 32'd1);
    sof_cycle(1'b1);
    check_val("coinc_flush_clear", 32'(o_pipe_flush), 32'd0);
    check_val("coinc_fen_keep", 32'(o_filter_en), 32'hF);

    // Reset while a flush is pending
    i_cfg_done = 1'b0;
    i_sw       = 4'b0000;
    tick(8);
    check_val("mid_pending", 32'(o_pipe_flush), 32'd1);
    i_rstn = 1'b0;
    tick(1);
    check_val("mid_rst_fen", 32'(o_filter_en), 32'd0);
    check_val("mid_rst_flush", 32'(o_pipe_flush), 32'd1);
    check_val("mid_rst_leds", 32'(o_status_leds), 32'h10);
    check_val("mid_rst_start", 32'(o_cfg_start), 32'd0);
    tick(1);
    i_rstn = 1'b1;
    tick(1);
    check_val("mid_restart", 32'(o_cfg_start), 32'd1);

    // No cfg_done: three attempts 21 cycles apart, then failure
    pulses = 1;
    p2     = -1;
    p3     = -1;
    err_at = -1;
    for (int n = 1; n <= 80; n++) begin
      tick(1);
      if (o_cfg_start) begin
        pulses++;
        if (pulses == 2) p2 = n;
        if (pulses == 3) p3 = n;
      end
      if (o_cfg_error && (err_at < 0)) err_at = n;
    end
    check_val("retry_pulses", 32'(pulses), 32'd3);
    check_val("retry_p2", 32'(p2), 32'd21);
    check_val("retry_p3", 32'(p3), 32'd42);
    check_val("retry_err_at", 32'(err_at), 32'd62);
    check_val("fail_err", 32'(o_cfg_error), 32'd1);
    check_val("fail_leds", 32'(o_status_leds), 32'h50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_control.md
PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 SHALL have parameter NUM_SW, default 4: number of filter-enable switches, range 1..8.
REQ-002 SHALL have parameter DB_CYCLES, default 16: consecutive stable cycles needed to accept a switch change, minimum 2.
REQ-003 SHALL have parameter CFG_TIMEOUT, default 1000000: cycles to wait for i_cfg_done before a retry.
REQ-004 SHALL have parameter MAX_RETRY, default 3: number of configuration retries allowed after the first attempt.
REQ-005 SHALL have port i_sysclk, input, 1: system clock; all logic on its rising edge.
REQ-006 SHALL have port i_rstn, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port i_sof, input, 1: start-of-frame, one-cycle pulse.
REQ-008 SHALL have port i_cfg_done, input, 1: camera configuration complete; sampled as a level.
REQ-009 SHALL have port i_sw, input, NUM_SW: raw asynchronous filter switches.
REQ-010 SHALL have port o_cfg_start, output, 1: one-cycle configuration start pulse.
REQ-011 SHALL have port o_pipe_flush, output, 1: pipeline flush request.
REQ-012 SHALL have port o_filter_en, output, NUM_SW: frame-aligned filter enables.
REQ-013 SHALL have port o_cfg_error, output, 1: configuration failed after all retries.
REQ-014 SHALL have port o_status_leds, output, 8: board status.

Function
REQ-015 SHALL pass each i_sw bit through a 2-flop synchronizer before any other use.
REQ-016 SHALL update the debounced value of a bit only after its synchronized value has differed from it for DB_CYCLES consecutive cycles; any match clears that bit's counter; the counter is $clog2(DB_CYCLES+1) bits.
REQ-017 SHALL register a change event one cycle after any debounced bit changes.
REQ-018 Configuration FSM SHALL use states CFG_START, CFG_WAIT, CFG_ACTIVE and CFG_FAIL.
REQ-019 CFG_START SHALL drive o_cfg_start high for exactly one cycle, clear the timeout counter and go to CFG_WAIT.
REQ-020 CFG_WAIT SHALL go to CFG_ACTIVE on i_cfg_done = 1; CFG_ACTIVE is held until reset.
REQ-021 CFG_WAIT timeout SHALL occur when the timeout counter reaches CFG_TIMEOUT without i_cfg_done; i_cfg_done in the timeout cycle wins.
REQ-022 On timeout with retries used < MAX_RETRY, the FSM SHALL increment the retry count and return to CFG_START.
REQ-023 On timeout with retries used = MAX_RETRY, the FSM SHALL go to CFG_FAIL and set o_cfg_error = 1 until reset.
REQ-024 Flush FSM SHALL use states FL_INITIAL, FL_IDLE and FL_PENDING.
REQ-025 FL_INITIAL SHALL set flush = 1 and go to FL_IDLE on i_sof while in CFG_ACTIVE, loading o_filter_en from the debounced value.
REQ-026 FL_IDLE SHALL set flush = 0 and go to FL_PENDING on a change event; an i_sof in the same cycle is ignored.
REQ-027 FL_PENDING SHALL set flush = 1 and, on i_sof, load o_filter_en from the debounced value and go to FL_IDLE.
REQ-028 In FL_PENDING, a change event coincident with i_sof SHALL load the current value but remain in FL_PENDING for one more frame.
REQ-029 o_pipe_flush SHALL be registered and reflect a state entry in the following cycle.
REQ-030 o_filter_en SHALL change only on an i_sof cycle.
REQ-031 o_status_leds SHALL map as follows: [3:0] = o_filter_en low bits, zero-padded; [4] = o_pipe_flush; [5] = CFG_ACTIVE; [6] = o_cfg_error; [7] = toggles on each i_sof while in CFG_ACTIVE.

Reset
REQ-032 When i_rstn = 0 at a clock edge, the block SHALL set o_cfg_start = 0, o_pipe_flush = 1, o_filter_en = 0, o_cfg_error = 0, o_status_leds = 8'h10, and clear all synchronizers, debounce counters, retry and timeout counters.
REQ-033 After reset the FSMs SHALL be in CFG_START and FL_INITIAL, so o_cfg_start pulses in the first cycle after i_rstn rises.
REQ-034 Reset mid-operation, including during CFG_WAIT or FL_PENDING, SHALL abandon all progress with no output glitch beyond the REQ-032 values.

Structure
REQ-035 Package pipe_control_pkg SHALL hold the CFG and FL state encodings and the LED bit-index constants.
REQ-036 SHALL instantiate one sub-module, sw_debounce (synchronizer plus counter, single bit, DB_CYCLES parameter), once per switch via generate.

Verification (bench: NUM_SW=4, DB_CYCLES=4, CFG_TIMEOUT=20, MAX_RETRY=2)
REQ-037 Reset released, i_cfg_done high 5 cycles after the o_cfg_start pulse, then i_sof -> flush drops on the cycle after i_sof and LED[5] = 1.
REQ-038 i_cfg_done held low -> exactly 3 o_cfg_start pulses about 21 cycles apart, then o_cfg_error = 1 and LED[6] = 1.
REQ-039 i_sw = 4'b0001 bouncing at a 2-cycle period, then stable -> no change event until stable for 4 cycles.
REQ-040 Debounced i_sw changes 4'b0000 -> 4'b0101 mid-frame -> flush = 1 next cycle, o_filter_en = 4'b0101 exactly at the next i_sof, flush = 0 the cycle after.
REQ-041 Change event coincident with i_sof in FL_PENDING -> o_filter_en loads, flush stays 1 until the following i_sof.
REQ-042 i_rstn low during FL_PENDING -> o_filter_en = 0, flush = 1, new o_cfg_start pulse after release.
